lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit in the MEM stage, directly downstream of the EX/MEM pipeline register.
- Issues data-bus transactions for load/store micro-ops and aligns, extends and merges load data.
- Detects misaligned and faulting accesses and raises a stall request to ctrl while a transaction is outstanding.
- All other fields (GPR/CSR write, exception, pc, inst) pass through to the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 255: wait cycles (WAIT_GNT plus WAIT_RVALID) before declaring an access fault; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- n_rst_i  in  1  synchronous reset, active-low
- flush_i  in  1  pipeline flush from ctrl
- rd_we_i, rd_addr_i, rd_wdata_i  in  1/`RegAddrBus/`RegBus  GPR write fields from ex_mem
- uopcode_i  in  `AluOpBus  micro-op
- mem_addr_i, mem_wdata_i  in  `RegBus  effective address and store data
- csr_we_i, csr_waddr_i, csr_wdata_i  in  1/`RegBus/`RegBus  CSR write fields
- exception_i, pc_i, inst_i  in  `RegBus  exception vector, pc, instruction
- data_req_o, data_we_o  out  1  bus request, write enable
- data_be_o  out  4  byte enables
- data_addr_o, data_wdata_o  out  32  word-aligned address, lane-shifted store data
- data_gnt_i, data_rvalid_i, data_err_i  in  1  grant, response valid, response error
- data_rdata_i  in  32  read data
- rd_we_o, rd_addr_o, rd_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o  out  as inputs  to mem_wb
- exception_o, pc_o, inst_o, mtval_o  out  `RegBus  exception vector, pc, inst, faulting address
- stall_req_o  out  1  stall request to ctrl

Behaviour:
- Reset (n_rst_i low at a clock edge): state goes to IDLE, timeout counter clears.
- While n_rst_i is low, data_req_o, stall_req_o, rd_we_o, csr_we_o, exception_o and mtval_o are forced to 0.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID, DRAIN.
- Access condition: uopcode_i in {LB, LH, LW, LBU, LHU, SB, SH, SW}, exception_i == 0, and the address is aligned.
  - Half-word ops require addr[0] = 0.
  - Word ops require addr[1:0] = 0.
- Non-access op in IDLE: all fields pass combinationally with 0 added latency; stall_req_o = 0.
- Misaligned access:
  - No request is issued; rd_we_o = 0.
  - exception_o = exception_i | `EXC_LOAD_MISALIGN or `EXC_STORE_MISALIGN.
  - mtval_o = mem_addr_i.
- Incoming exception_i != 0: no request is issued; exception_o passes through unchanged.
- IDLE with access:
  - Drives data_req_o = 1 and data_addr_o = {addr[31:2], 2'b00}.
  - Byte enables: SB 0001 << a; SH 0011 << a; SW 1111.
  - data_wdata_o is mem_wdata_i replicated into the addressed lane.
  - stall_req_o = 1.
  - gnt high -> WAIT_RVALID; gnt low -> WAIT_GNT.
- WAIT_GNT: request and fields held (ex_mem is frozen by the stall); gnt -> WAIT_RVALID.
- WAIT_RVALID: data_req_o = 0 and stall_req_o = 1 until data_rvalid_i.
- Cycle in which rvalid is high:
  - stall_req_o = 0; state returns to IDLE.
  - rd_wdata_o = selected byte/half of data_rdata_i, sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Stores keep rd_we_o = 0.
- data_err_i with rvalid, or the timeout expiring:
  - rd_we_o = 0; csr_we_o = 0.
  - exception_o gains `EXC_LOAD_FAULT or `EXC_STORE_FAULT.
  - mtval_o = mem_addr_i.
- Minimum load latency: 1 stall cycle (gnt in the request cycle, rvalid the next cycle).
- Flush in WAIT_GNT: request is withdrawn and state goes to IDLE. A withdrawn request is legal on this bus while ungranted.
- Flush in WAIT_RVALID: state goes to DRAIN; stall_req_o stays 1; the response is absorbed and not written back. On rvalid, DRAIN -> IDLE.
- Flush in IDLE: outputs are unaffected; ex_mem inserts the bubble.
- ctrl must hold stall_i[4:0] = Stop while stall_req_o = 1 so that the ex_mem outputs stay stable.
- Timeout counter: 8+ bits, clears on entering IDLE, saturates, and compares against TIMEOUT_CYCLES.

Decomposition:
- Add to defines.v:
  - Load/store UOP_CODE_* constants.
  - EXC_* bit positions for the exception vector.
  - LSU FSM state encodings.
- One natural sub-module, lsu_align: combinational byte-enable/store-lane generation and load extraction/extension.

Test Plan:
- LW at addr 0x100, gnt in the same cycle, rdata 0xDEADBEEF the next cycle -> stall_req_o high for 1 cycle; rd_wdata_o = 0xDEADBEEF; rd_we_o = 1.
- LB at addr 0x103, rdata 0x80FFFFFF -> data_be_o = 1000; rd_wdata_o = 0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH at addr 0x102, data 0x1234ABCD, gnt delayed 3 cycles -> data_be_o = 1100 and data_wdata_o = 0xABCDxxxx held 3 cycles; rd_we_o = 0.
- LW at addr 0x101 -> no data_req_o; exception_o has EXC_LOAD_MISALIGN; mtval_o = 0x101; stall_req_o = 0.
- SW granted, then flush_i in WAIT_RVALID, rvalid 2 cycles later -> state DRAIN; stall_req_o held until rvalid; no writeback; returns to IDLE.
- LW with TIMEOUT_CYCLES = 4 and no rvalid -> after 4 cycles, EXC_LOAD_FAULT set and stall_req_o drops. Separately, n_rst_i low mid-access -> data_req_o = 0 and state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - bus widths for GPR data, GPR address and micro-op code
//   - load/store micro-op codes and exception-vector bit masks
//   - LSU FSM state encoding and a micro-op decode helper
package lsu_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int UOP_W      = 8;

  localparam logic [UOP_W-1:0] UOP_CODE_NOP = 8'h00;
  localparam logic [UOP_W-1:0] UOP_CODE_LB  = 8'h30;
  localparam logic [UOP_W-1:0] UOP_CODE_LH  = 8'h31;
  localparam logic [UOP_W-1:0] UOP_CODE_LW  = 8'h32;
  localparam logic [UOP_W-1:0] UOP_CODE_LBU = 8'h33;
  localparam logic [UOP_W-1:0] UOP_CODE_LHU = 8'h34;
  localparam logic [UOP_W-1:0] UOP_CODE_SB  = 8'h38;
  localparam logic [UOP_W-1:0] UOP_CODE_SH  = 8'h39;
  localparam logic [UOP_W-1:0] UOP_CODE_SW  = 8'h3A;

  // One-hot bits OR-ed into the exception vector travelling down the pipe.
  localparam logic [REG_W-1:0] EXC_LOAD_MISALIGN  = 32'h0000_0010;
  localparam logic [REG_W-1:0] EXC_LOAD_FAULT     = 32'h0000_0020;
  localparam logic [REG_W-1:0] EXC_STORE_MISALIGN = 32'h0000_0040;
  localparam logic [REG_W-1:0] EXC_STORE_FAULT    = 32'h0000_0080;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'd0,
    LSU_WAIT_GNT    = 2'd1,
    LSU_WAIT_RVALID = 2'd2,
    LSU_DRAIN       = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    mem_size_e size;
    logic      is_signed;
  } uop_info_t;

  function automatic uop_info_t decode_uop(input logic [UOP_W-1:0] uop);
    uop_info_t info;
    info.is_load   = 1'b0;
    info.is_store  = 1'b0;
    info.size      = SIZE_W;
    info.is_signed = 1'b0;
    case (uop)
      UOP_CODE_LB:  begin info.is_load  = 1'b1; info.size = SIZE_B; info.is_signed = 1'b1; end
      UOP_CODE_LH:  begin info.is_load  = 1'b1; info.size = SIZE_H; info.is_signed = 1'b1; end
      UOP_CODE_LW:  begin info.is_load  = 1'b1; info.size = SIZE_W; end
      UOP_CODE_LBU: begin info.is_load  = 1'b1; info.size = SIZE_B; end
      UOP_CODE_LHU: begin info.is_load  = 1'b1; info.size = SIZE_H; end
      UOP_CODE_SB:  begin info.is_store = 1'b1; info.size = SIZE_B; end
      UOP_CODE_SH:  begin info.is_store = 1'b1; info.size = SIZE_H; end
      UOP_CODE_SW:  begin info.is_store = 1'b1; info.size = SIZE_W; end
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   size, is_signed, addr_lo : access size, load extension, address bits [1:0]
//   wdata -> lane_wdata, be  : store data replicated across lanes, byte enables
//   rdata -> load_data       : addressed byte/half/word, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  mem_size_e        size,
  input  logic             is_signed,
  input  logic [1:0]       addr_lo,
  input  logic [REG_W-1:0] wdata,
  input  logic [REG_W-1:0] rdata,
  output logic [3:0]       be,
  output logic [REG_W-1:0] lane_wdata,
  output logic [REG_W-1:0] load_data
);

  logic [REG_W-1:0] shifted;

  // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata;
    load_data  = rdata;
    // Move the addressed byte down to bit 0; halves are aligned so the same shift works.
    shifted    = rdata >> {addr_lo, 3'b000};
    case (size)
      SIZE_B: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        be         = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit.
//   ex_mem fields in  : rd_*, uopcode, mem_addr/wdata, csr_*, exception, pc, inst
//   data bus          : data_req/we/be/addr/wdata out; data_gnt/rvalid/err/rdata in
//   mem_wb fields out : rd_*, csr_*, exception, pc, inst, mtval (faulting address)
//   stall_req_o       : held high while a bus transaction is outstanding
// Fields pass combinationally; ex_mem stays frozen while stall_req_o is high.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic                  flush_i,
  input  logic                  rd_we_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [REG_W-1:0]      rd_wdata_i,
  input  logic [UOP_W-1:0]      uopcode_i,
  input  logic [REG_W-1:0]      mem_addr_i,
  input  logic [REG_W-1:0]      mem_wdata_i,
  input  logic                  csr_we_i,
  input  logic [REG_W-1:0]      csr_waddr_i,
  input  logic [REG_W-1:0]      csr_wdata_i,
  input  logic [REG_W-1:0]      exception_i,
  input  logic [REG_W-1:0]      pc_i,
  input  logic [REG_W-1:0]      inst_i,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_addr_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_err_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  rd_we_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [REG_W-1:0]      rd_wdata_o,
  output logic                  csr_we_o,
  output logic [REG_W-1:0]      csr_waddr_o,
  output logic [REG_W-1:0]      csr_wdata_o,
  output logic [REG_W-1:0]      exception_o,
  output logic [REG_W-1:0]      pc_o,
  output logic [REG_W-1:0]      inst_o,
  output logic [REG_W-1:0]      mtval_o,
  output logic                  stall_req_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e       state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  uop_info_t        uop;
  logic             misaligned, timeout_hit, fault, squash;
  logic [REG_W-1:0] load_data;

  assign uop        = decode_uop(uopcode_i);
  assign misaligned = ((uop.size == SIZE_H) && mem_addr_i[0]) ||
                      ((uop.size == SIZE_W) && (mem_addr_i[1:0] != 2'b00));
  // wait_cnt holds the wait cycles already completed, so this fires on the
  // TIMEOUT_CYCLES-th cycle spent waiting.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(wait_cnt) + 32'd1) >= 32'(TIMEOUT_CYCLES));

  assign data_we_o   = uop.is_store;
  assign data_addr_o = {mem_addr_i[31:2], 2'b00};

  lsu_align u_align (
    .size       (uop.size),
    .is_signed  (uop.is_signed),
    .addr_lo    (mem_addr_i[1:0]),
    .wdata      (mem_wdata_i),
    .rdata      (data_rdata_i),
    .be         (data_be_o),
    .lane_wdata (data_wdata_o),
    .load_data  (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state    <= LSU_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next == LSU_IDLE) begin
        wait_cnt <= '0;
      end else if ((state != LSU_IDLE) && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    data_req_o  = 1'b0;
    stall_req_o = 1'b0;
    fault       = 1'b0;
    squash      = 1'b0;
    rd_we_o     = rd_we_i;
    rd_addr_o   = rd_addr_i;
    rd_wdata_o  = rd_wdata_i;
    csr_we_o    = csr_we_i;
    csr_waddr_o = csr_waddr_i;
    csr_wdata_o = csr_wdata_i;
    exception_o = exception_i;
    pc_o        = pc_i;
    inst_o      = inst_i;
    mtval_o     = '0;

    case (state)
      LSU_IDLE: begin
        if ((uop.is_load || uop.is_store) && (exception_i == '0)) begin
          if (misaligned) begin
            rd_we_o     = 1'b0;
            exception_o = exception_i |
                          (uop.is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN);
            mtval_o     = mem_addr_i;
          end else begin
            data_req_o  = 1'b1;
            stall_req_o = 1'b1;
            state_next  = data_gnt_i ? LSU_WAIT_RVALID : LSU_WAIT_GNT;
          end
        end
      end
      LSU_WAIT_GNT: begin
        if (flush_i) begin
          // Withdraw in the same cycle so a late grant cannot orphan a response.
          squash     = 1'b1;
          state_next = LSU_IDLE;
        end else if (data_gnt_i) begin
          data_req_o  = 1'b1;
          stall_req_o = 1'b1;
          state_next  = LSU_WAIT_RVALID;
        end else if (timeout_hit) begin
          fault      = 1'b1;
          state_next = LSU_IDLE;
        end else begin
          data_req_o  = 1'b1;
          stall_req_o = 1'b1;
        end
      end
      LSU_WAIT_RVALID: begin
        if (data_rvalid_i) begin
          state_next = LSU_IDLE;
          if (data_err_i) begin
            fault = 1'b1;
          end else begin
            rd_we_o = rd_we_i & uop.is_load;
            if (uop.is_load) rd_wdata_o = load_data;
          end
        end else if (timeout_hit) begin
          fault      = 1'b1;
          state_next = LSU_IDLE;
        end else begin
          stall_req_o = 1'b1;
          if (flush_i) state_next = LSU_DRAIN;
        end
      end
      LSU_DRAIN: begin
        squash = 1'b1;
        if (data_rvalid_i || timeout_hit) begin
          state_next = LSU_IDLE;
        end else begin
          stall_req_o = 1'b1;
        end
      end
      default: state_next = LSU_IDLE;
    endcase

    if (stall_req_o || squash) begin
      rd_we_o  = 1'b0;
      csr_we_o = 1'b0;
    end
    if (fault) begin
      rd_we_o     = 1'b0;
      csr_we_o    = 1'b0;
      exception_o = exception_i | (uop.is_load ? EXC_LOAD_FAULT : EXC_STORE_FAULT);
      mtval_o     = mem_addr_i;
    end
    if (!n_rst_i) begin
      data_req_o  = 1'b0;
      stall_req_o = 1'b0;
      rd_we_o     = 1'b0;
      csr_we_o    = 1'b0;
      exception_o = '0;
      mtval_o     = '0;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver pushes expected bus requests and
// expected retire results; a negedge monitor compares them against the DUT.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        n_rst_i, flush_i, rd_we_i, csr_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_wdata_i, mem_addr_i, mem_wdata_i, csr_waddr_i, csr_wdata_i;
  logic [31:0] exception_i, pc_i, inst_i, data_rdata_i;
  logic [7:0]  uopcode_i;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic        data_req_o, data_we_o, rd_we_o, csr_we_o, stall_req_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, rd_wdata_o, csr_waddr_o, csr_wdata_o;
  logic [31:0] exception_o, pc_o, inst_o, mtval_o;
  logic [4:0]  rd_addr_o;

  always #5 clk_i = ~clk_i;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .flush_i(flush_i),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i),
    .uopcode_i(uopcode_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .exception_i(exception_i), .pc_i(pc_i), .inst_i(inst_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_rdata_i(data_rdata_i),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .exception_o(exception_o), .pc_o(pc_o), .inst_o(inst_o), .mtval_o(mtval_o),
    .stall_req_o(stall_req_o)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          stall;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic [31:0] exc;
    logic [31:0] mtval;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];
  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  bit tracking = 1'b0;
  bit retired  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus_exp_t b;
    b.we = we; b.be = be; b.addr = addr; b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  task automatic exp_res(input int stall, input logic rd_we, input logic [31:0] rd_wdata,
                         input logic [31:0] exc, input logic [31:0] mtval);
    res_exp_t r;
    r.stall = stall; r.rd_we = rd_we; r.rd_wdata = rd_wdata; r.exc = exc; r.mtval = mtval;
    res_q.push_back(r);
  endtask

  task automatic drive_nop();
    uopcode_i = UOP_CODE_NOP; mem_addr_i = '0; mem_wdata_i = '0;
    rd_we_i = 1'b0; rd_wdata_i = '0; exception_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; flush_i = 1'b0;
  endtask

  // Called just after a posedge. gnt_d: cycle of grant (-1 none);
  // rv_d: cycles from grant to rvalid (-1 none); flush_c: flush cycle (-1 none).
  task automatic issue(input logic [7:0] uop, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rd_we, input logic [31:0] rd_wdata, input logic [31:0] exc,
                       input int gnt_d, input int rv_d, input logic err, input int flush_c,
                       input logic [31:0] rdata);
    uopcode_i = uop; mem_addr_i = addr; mem_wdata_i = wdata;
    rd_we_i = rd_we; rd_wdata_i = rd_wdata; exception_i = exc;
    data_rdata_i = rdata; pc_i = pc_i + 32'd4;
    retired = 1'b0; stall_cnt = 0; tracking = 1'b1;
    for (int c = 0; c < 20; c++) begin
      data_gnt_i    = (c == gnt_d);
      data_rvalid_i = (gnt_d >= 0) && (rv_d >= 0) && (c == gnt_d + rv_d);
      data_err_i    = data_rvalid_i && err;
      flush_i       = (c == flush_c);
      @(posedge clk_i); #1;
      if (retired) break;
    end
    if (!retired) begin
      check("retire_budget", 32'd0, 32'd1);
      tracking = 1'b0;
      if (res_q.size() != 0) void'(res_q.pop_front());
    end
    drive_nop();
  endtask

  initial begin : monitor
    bus_exp_t b;
    res_exp_t r;
    forever begin
      @(negedge clk_i);
      if (n_rst_i && data_req_o) begin
        if (bus_q.size() == 0) begin
          check("unexpected_req", {31'b0, data_req_o}, 32'd0);
        end else begin
          b = bus_q[0];
          check("bus_we", {31'b0, data_we_o}, {31'b0, b.we});
          check("bus_be", {28'b0, data_be_o}, {28'b0, b.be});
          check("bus_addr", data_addr_o, b.addr);
          check("bus_wdata", data_wdata_o, b.wdata);
          if (data_gnt_i) void'(bus_q.pop_front());
        end
      end
      if (tracking) begin
        if (stall_req_o) begin
          stall_cnt++;
        end else begin
          if (res_q.size() == 0) begin
            check("unexpected_retire", 32'd1, 32'd0);
          end else begin
            r = res_q.pop_front();
            check("stall_cycles", 32'(stall_cnt), 32'(r.stall));
            check("rd_we", {31'b0, rd_we_o}, {31'b0, r.rd_we});
            check("rd_wdata", rd_wdata_o, r.rd_wdata);
            check("exception", exception_o, r.exc);
            check("mtval", mtval_o, r.mtval);
            check("pc_pass", pc_o, pc_i);
          end
          tracking = 1'b0;
          retired  = 1'b1;
        end
      end
    end
  end

  initial begin : driver
    n_rst_i = 1'b0; drive_nop(); data_rdata_i = '0; pc_i = 32'h1000; inst_i = 32'h0000_0013;
    rd_addr_i = 5'd7; csr_we_i = 1'b0; csr_waddr_i = '0; csr_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    // Outputs forced low during reset even with an access and an exception presented.
    uopcode_i = UOP_CODE_LW; mem_addr_i = 32'h101; rd_we_i = 1'b1;
    exception_i = 32'h4; data_gnt_i = 1'b1;
    @(negedge clk_i);
    check("rst_req", {31'b0, data_req_o}, 32'd0);
    check("rst_stall", {31'b0, stall_req_o}, 32'd0);
    check("rst_rd_we", {31'b0, rd_we_o}, 32'd0);
    check("rst_exc", exception_o, 32'd0);
    check("rst_mtval", mtval_o, 32'd0);
    @(posedge clk_i); #1;
    drive_nop(); n_rst_i = 1'b1;
    @(posedge clk_i); #1;

    // LW, grant in request cycle, data next cycle.
    exp_bus(1'b0, 4'b1111, 32'h100, 32'h0);
    exp_res(1, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0);
    issue(UOP_CODE_LW, 32'h100, 32'h0, 1'b1, 32'h0, 32'h0, 0, 1, 1'b0, -1, 32'hDEADBEEF);
    // LB / LBU at the top byte.
    exp_bus(1'b0, 4'b1000, 32'h100, 32'h0);
    exp_res(1, 1'b1, 32'hFFFFFF80, 32'h0, 32'h0);
    issue(UOP_CODE_LB, 32'h103, 32'h0, 1'b1, 32'h0, 32'h0, 0, 1, 1'b0, -1, 32'h80FFFFFF);
    exp_bus(1'b0, 4'b1000, 32'h100, 32'h0);
    exp_res(1, 1'b1, 32'h00000080, 32'h0, 32'h0);
    issue(UOP_CODE_LBU, 32'h103, 32'h0, 1'b1, 32'h0, 32'h0, 0, 1, 1'b0, -1, 32'h80FFFFFF);
    // LH upper half (sign), LHU lower half (zero).
    exp_bus(1'b0, 4'b1100, 32'h100, 32'h0);
    exp_res(1, 1'b1, 32'hFFFF8001, 32'h0, 32'h0);
    issue(UOP_CODE_LH, 32'h102, 32'h0, 1'b1, 32'h0, 32'h0, 0, 1, 1'b0, -1, 32'h80017FFF);
    exp_bus(1'b0, 4'b0011, 32'h100, 32'h0);
    exp_res(1, 1'b1, 32'h00007FFF, 32'h0, 32'h0);
    issue(UOP_CODE_LHU, 32'h100, 32'h0, 1'b1, 32'h0, 32'h0, 0, 1, 1'b0, -1, 32'h80017FFF);
    // SH, request held three cycles before grant.
    exp_bus(1'b1, 4'b1100, 32'h100, 32'hABCDABCD);
    exp_res(3, 1'b0, 32'h0, 32'h0, 32'h0);
    issue(UOP_CODE_SH, 32'h102, 32'h1234ABCD, 1'b0, 32'h0, 32'h0, 2, 1, 1'b0, -1, 32'h0);
    // SB lane 1.
    exp_bus(1'b1, 4'b0010, 32'h100, 32'hA5A5A5A5);
    exp_res(1, 1'b0, 32'h0, 32'h0, 32'h0);
    issue(UOP_CODE_SB, 32'h101, 32'h000000A5, 1'b0, 32'h0, 32'h0, 0, 1, 1'b0, -1, 32'h0);
    // Misaligned load and store: no request even with gnt high.
    exp_res(0, 1'b0, 32'h0, EXC_LOAD_MISALIGN, 32'h101);
    issue(UOP_CODE_LW, 32'h101, 32'h0, 1'b1, 32'h0, 32'h0, 0, -1, 1'b0, -1, 32'h0);
    exp_res(0, 1'b0, 32'h0, EXC_STORE_MISALIGN, 32'h201);
    issue(UOP_CODE_SH, 32'h201, 32'h0, 1'b0, 32'h0, 32'h0, 0, -1, 1'b0, -1, 32'h0);
    // Incoming exception passes unchanged, no request.
    exp_res(0, 1'b1, 32'h0, 32'h4, 32'h0);
    issue(UOP_CODE_LW, 32'h100, 32'h0, 1'b1, 32'h0, 32'h4, 0, -1, 1'b0, -1, 32'h0);
    // Non-access op passes through.
    exp_res(0, 1'b1, 32'h55, 32'h0, 32'h0);
    issue(UOP_CODE_NOP, 32'h0, 32'h0, 1'b1, 32'h55, 32'h0, -1, -1, 1'b0, -1, 32'h0);
    // SW granted, flush in WAIT_RVALID, response two cycles later is drained.
    exp_bus(1'b1, 4'b1111, 32'h104, 32'hCAFEF00D);
    exp_res(3, 1'b0, 32'h0, 32'h0, 32'h0);
    issue(UOP_CODE_SW, 32'h104, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 0, 3, 1'b0, 1, 32'h0);
    // Load bus error.
    exp_bus(1'b0, 4'b1111, 32'h108, 32'h0);
    exp_res(1, 1'b0, 32'h0, EXC_LOAD_FAULT, 32'h108);
    issue(UOP_CODE_LW, 32'h108, 32'h0, 1'b1, 32'h0, 32'h0, 0, 1, 1'b1, -1, 32'h12345678);
    // Load timeout: no rvalid, fault on the fourth wait cycle.
    exp_bus(1'b0, 4'b1111, 32'h10C, 32'h0);
    exp_res(4, 1'b0, 32'h0, EXC_LOAD_FAULT, 32'h10C);
    issue(UOP_CODE_LW, 32'h10C, 32'h0, 1'b1, 32'h0, 32'h0, 0, -1, 1'b0, -1, 32'h0);

    // Reset in the middle of an ungranted access.
    exp_bus(1'b0, 4'b1111, 32'h200, 32'h0);
    uopcode_i = UOP_CODE_LW; mem_addr_i = 32'h200; rd_we_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    n_rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_req", {31'b0, data_req_o}, 32'd0);
    check("midrst_stall", {31'b0, stall_req_o}, 32'd0);
    @(posedge clk_i); #1;
    drive_nop(); n_rst_i = 1'b1;
    if (bus_q.size() != 0) void'(bus_q.pop_front());
    @(negedge clk_i);
    check("midrst_idle_stall", {31'b0, stall_req_o}, 32'd0);
    @(posedge clk_i); #1;
    exp_bus(1'b0, 4'b1111, 32'h100, 32'h0);
    exp_res(1, 1'b1, 32'h0BADF00D, 32'h0, 32'h0);
    issue(UOP_CODE_LW, 32'h100, 32'h0, 1'b1, 32'h0, 32'h0, 0, 1, 1'b0, -1, 32'h0BADF00D);

    repeat (2) @(posedge clk_i);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    check("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
